// File: rtl/reg_seq_if.sv
// Command handshake and register-file control bundle for reg_seq.
// The master side issues commands and consumes the register-file controls;
// the slave side (reg_seq) accepts commands and drives the controls.
interface reg_seq_if;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [2:0] CMD_OP;
   logic [1:0] CMD_DST;
   logic [1:0] CMD_SRC;
   logic [7:0] CMD_DATA;
   logic       MRWE;
   logic       WA1;
   logic       WA0;
   logic       RA3;
   logic       RA2;
   logic       RA1;
   logic       RA0;
   logic       SWAPR;
   logic [7:0] WDATA;
   logic       WSEL;
   logic       DONE;
   logic       ERR;

   modport master (
      output CMD_VALID, CMD_OP, CMD_DST, CMD_SRC, CMD_DATA,
      input  CMD_READY, MRWE, WA1, WA0, RA3, RA2, RA1, RA0,
             SWAPR, WDATA, WSEL, DONE, ERR
   );

   modport slave (
      input  CMD_VALID, CMD_OP, CMD_DST, CMD_SRC, CMD_DATA,
      output CMD_READY, MRWE, WA1, WA0, RA3, RA2, RA1, RA0,
             SWAPR, WDATA, WSEL, DONE, ERR
   );
endinterface

// File: rtl/reg_seq.sv
// reg_seq: command sequencer for a 4-entry register file (A, B, C, IX).
// Accepts one command in IDLE and emits registered register-file control
// lines starting the cycle after acceptance. CLRALL (and ROTATE) run as
// multi-cycle sequences in MULTI.
// Optional feature: define REG_SEQ_ROTATE_EN to enable opcode 110 (ROTATE);
// without it opcode 110 is rejected like 111 and no rotate logic exists.
module reg_seq #(
   parameter logic [7:0] CLR_VALUE = 8'h00
) (
   input logic     CLK,
   input logic     RESET,
   reg_seq_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, MULTI} state_t;

   // One control cycle worth of register-file drive.
   typedef struct packed {
      logic       mrwe;
      logic [1:0] wa;
      logic [1:0] ra_lo;   // RA1:RA0
      logic [1:0] ra_hi;   // RA3:RA2
      logic       swapr;
      logic       wsel;
      logic [7:0] wdata;
      logic       done;
      logic       err;
   } ctl_t;

   state_t     state;
   logic [1:0] step;
   logic       ready;
   logic [2:0] op_q;
   ctl_t       ctl;

   // Step s of CLRALL: write CLR_VALUE to register s, last step is IX.
   function automatic ctl_t clrall_step(input logic [1:0] s);
      ctl_t c;
      c       = '0;
      c.mrwe  = 1'b1;
      c.wa    = s;
      c.wdata = CLR_VALUE;
      c.done  = (s == 2'd3);
      return c;
   endfunction

`ifdef REG_SEQ_ROTATE_EN
   // Step s of ROTATE: swap neighbours s and s+1; three swaps rotate left.
   function automatic ctl_t rotate_step(input logic [1:0] s);
      ctl_t c;
      c       = '0;
      c.swapr = 1'b1;
      c.ra_lo = s;
      c.ra_hi = s + 2'd1;
      c.done  = (s == 2'd2);
      return c;
   endfunction
`endif

   // Control for the first (or only) cycle of a freshly accepted command.
   function automatic ctl_t decode_cmd(input logic [2:0] op, input logic [1:0] dst,
                                       input logic [1:0] src, input logic [7:0] data);
      ctl_t c;
      c = '0;
      case (op)
         3'b000: c.done = 1'b1;
         3'b001: begin
            c.mrwe = 1'b1; c.wa = dst; c.wdata = data; c.done = 1'b1;
         end
         3'b010: begin
            c.mrwe = 1'b1; c.wa = dst; c.ra_lo = src; c.wsel = 1'b1; c.done = 1'b1;
         end
         3'b011: begin
            c.swapr = 1'b1; c.ra_lo = dst; c.ra_hi = src; c.done = 1'b1;
         end
         3'b100: begin
            c.mrwe = 1'b1; c.wa = dst; c.wdata = CLR_VALUE; c.done = 1'b1;
         end
         3'b101: c = clrall_step(2'd0);
`ifdef REG_SEQ_ROTATE_EN
         3'b110: c = rotate_step(2'd0);
`endif
         default: c.err = 1'b1;
      endcase
      return c;
   endfunction

   function automatic logic is_multi(input logic [2:0] op);
`ifdef REG_SEQ_ROTATE_EN
      return (op == 3'b101) || (op == 3'b110);
`else
      return (op == 3'b101);
`endif
   endfunction

   // Control for a later step of the multi-cycle command held in op_q.
   function automatic ctl_t next_step(input logic [2:0] op, input logic [1:0] s);
`ifdef REG_SEQ_ROTATE_EN
      if (op == 3'b110) return rotate_step(s);
`endif
      if (op == 3'b101) return clrall_step(s);
      return '0;
   endfunction

   // Sequencer FSM; every output comes straight from a register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= IDLE;
         step  <= 2'd0;
         ready <= 1'b1;
         op_q  <= 3'b000;
         ctl   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.CMD_VALID) begin
                  op_q  <= bus.CMD_OP;
                  ctl   <= decode_cmd(bus.CMD_OP, bus.CMD_DST, bus.CMD_SRC, bus.CMD_DATA);
                  ready <= 1'b0;
                  step  <= 2'd0;
                  state <= is_multi(bus.CMD_OP) ? MULTI : EXEC;
               end
            end
            EXEC: begin
               ctl   <= '0;
               ready <= 1'b1;
               step  <= 2'd0;
               state <= IDLE;
            end
            MULTI: begin
               if (ctl.done) begin
                  ctl   <= '0;
                  ready <= 1'b1;
                  step  <= 2'd0;
                  state <= IDLE;
               end else begin
                  step <= step + 2'd1;
                  ctl  <= next_step(op_q, step + 2'd1);
               end
            end
            default: begin
               ctl   <= '0;
               ready <= 1'b1;
               step  <= 2'd0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.CMD_READY = ready;
   assign bus.MRWE      = ctl.mrwe;
   assign bus.WA1       = ctl.wa[1];
   assign bus.WA0       = ctl.wa[0];
   assign bus.RA3       = ctl.ra_hi[1];
   assign bus.RA2       = ctl.ra_hi[0];
   assign bus.RA1       = ctl.ra_lo[1];
   assign bus.RA0       = ctl.ra_lo[0];
   assign bus.SWAPR     = ctl.swapr;
   assign bus.WSEL      = ctl.wsel;
   assign bus.WDATA     = ctl.wdata;
   assign bus.DONE      = ctl.done;
   assign bus.ERR       = ctl.err;

endmodule
